push_sw_debouncer: RTL and testbench
====================================

// Module: push_sw_debouncer
//
// PURPOSE
//   Conditions raw push-switch inputs ahead of the rising-edge/LED logic.
//   Per channel: 2-flop synchronizer, then counter-based debounce FSM.
//   Outputs a clean level and a one-clock rise pulse, which feed the edge/LED stage directly.
//   Channels are fully independent.
//
// PARAMETERS
//   NUM_SW        2        number of switch channels (>=1)
//   DEBOUNCE_CYC  500000   consecutive stable sync samples needed to accept a change (>=2; 10 ms @ 50 MHz)
//   CNT_W         $clog2(DEBOUNCE_CYC)  counter width (derived; do not override)
//
// PORTS
//   clk       in   1       system clock, all flops rising-edge
//   rstb      in   1       asynchronous, active-low reset
//   sw_raw    in   NUM_SW  raw switch pins, active-high, asynchronous to clk
//   sw_level  out  NUM_SW  debounced level, registered
//   sw_rise   out  NUM_SW  1-cycle pulse on accepted 0->1, registered
//   sw_fall   out  NUM_SW  1-cycle pulse on accepted 1->0 (only with SW_FALL_PULSE_EN)
//
// BEHAVIOUR
//   - Reset (rstb=0, async): sync flops=0, state=S_LOW, cnt=0, sw_level=0, sw_rise=0, sw_fall=0.
//   - Sync: s1<=sw_raw; s2<=s1. The FSM uses only s2.
//   - FSM per channel (the edges described are clk rising edges):
//     S_LOW   : s2=1 -> S_RISE, cnt<=1; else stay.
//     S_RISE  : s2=0 -> S_LOW, cnt<=0 (glitch rejected, no output).
//               s2=1 & cnt==DEBOUNCE_CYC-1 -> S_HIGH, sw_level<=1, sw_rise<=1.
//               otherwise cnt<=cnt+1.
//     S_HIGH  : s2=0 -> S_FALL, cnt<=1; else stay.
//     S_FALL  : mirror of S_RISE: s2=1 -> S_HIGH, cnt<=0.
//               Done -> S_LOW, sw_level<=0, sw_fall<=1 (if enabled).
//   - sw_rise/sw_fall are high for exactly one cycle. They are deasserted on every other edge.
//   - Latency: raw stable from edge 1 gives the sw_level change and rise pulse after edge DEBOUNCE_CYC+2.
//   - Any raw pulse narrower than DEBOUNCE_CYC cycles as seen at s2 produces no output.
//     Bouncing restarts the count.
//   - cnt never exceeds DEBOUNCE_CYC-1; no wrap-around is possible.
//   - Reset mid-count abandons the count. If the switch is still held after reset release,
//     it is re-debounced from S_LOW and issues a fresh sw_rise.
//   - Simultaneous activity on several channels is processed independently in the same cycle.
//
// CONFIGURATION
//   SW_FALL_PULSE_EN defined:
//     - sw_fall port exists.
//     - Pulses for one cycle on the S_FALL->S_LOW transition.
//   SW_FALL_PULSE_EN undefined:
//     - No sw_fall port and no fall-pulse flops.
//     - The FSM and sw_level are unchanged.
//
// STRUCTURE
//   - Package push_sw_pkg holds:
//     - typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} sw_state_t
//     - localparam DEFAULT_DEBOUNCE_CYC = 500000
//   - Sub-module push_sw_debounce_ch is one channel (synchronizer + FSM + counter).
//     The top instantiates it NUM_SW times in a generate loop and concatenates the outputs.
//
// TESTING  (bench overrides DEBOUNCE_CYC=4, NUM_SW=2, 10 ns clock)
//   1. Reset held 20 ns with sw_raw=2'b11
//      -> sw_level=0, sw_rise=0 throughout reset.
//      After release: rise pulses on both channels 6 edges later, same cycle.
//   2. sw_raw[0] 0->1 held 10 cycles
//      -> sw_level[0]=1 after edge 6; sw_rise[0]=1 for exactly that one cycle.
//   3. sw_raw[1] high for 3 cycles, then low
//      -> sw_level[1] and sw_rise[1] stay 0.
//   4. sw_raw[0] bounces 1,0,1,0,1 (1 cycle each), then holds 1
//      -> single sw_rise[0], 6 edges after the final stable 1 is sampled.
//   5. sw_level[0]=1, drop sw_raw[0] to 0, assert rstb=0 after 2 cycles, release, keep raw 0
//      -> outputs 0 immediately on reset; no sw_rise/sw_fall after release.
//   6. With SW_FALL_PULSE_EN: sw_raw[1] 1->0 held
//      -> sw_fall[1] pulses 1 cycle, 6 edges after change; sw_level[1] falls the same edge.

Source files
------------

// File: rtl/push_sw_pkg.sv
// Shared types and defaults for the push-switch debouncer.
package push_sw_pkg;

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} sw_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYC = 500000;

endpackage

// File: rtl/push_sw_debounce_ch.sv
// One switch channel: 2-flop synchronizer feeding a counter-based debounce FSM.
// Fall pulse output exists only when SW_FALL_PULSE_EN is defined.
module push_sw_debounce_ch
    import push_sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rstb,
    input  logic sw_raw_i,
    output logic level_o,
    output logic rise_o
`ifdef SW_FALL_PULSE_EN
    ,
    output logic fall_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             s1_q, s2_q;
    sw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
`ifdef SW_FALL_PULSE_EN
    logic             fall_q, fall_d;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef SW_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            s1_q    <= sw_raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef SW_FALL_PULSE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    // Any sample disagreeing with the pending level sends the FSM back and discards the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef SW_FALL_PULSE_EN
        fall_d  = 1'b0;
`endif
        unique case (state_q)
            S_LOW: begin
                if (s2_q) begin
                    state_d = S_RISE;
                    cnt_d   = CntOne;
                end
            end
            S_RISE: begin
                if (!s2_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d = S_FALL;
                    cnt_d   = CntOne;
                end
            end
            S_FALL: begin
                if (s2_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef SW_FALL_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
`ifdef SW_FALL_PULSE_EN
    assign fall_o  = fall_q;
`endif

endmodule

// File: rtl/push_sw_debouncer.sv
// Multi-channel push-switch debouncer; channels are independent instances.
// Define SW_FALL_PULSE_EN to add the sw_fall pulse output.
module push_sw_debouncer
    import push_sw_pkg::*;
#(
    parameter int unsigned NUM_SW       = 2,
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise
`ifdef SW_FALL_PULSE_EN
    ,
    output logic [NUM_SW-1:0] sw_fall
`endif
);

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        push_sw_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_ch (
            .clk     (clk),
            .rstb    (rstb),
            .sw_raw_i(sw_raw[i]),
            .level_o (sw_level[i]),
            .rise_o  (sw_rise[i])
`ifdef SW_FALL_PULSE_EN
            ,
            .fall_o  (sw_fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_push_sw_debouncer.sv
// Directed table-driven bench for push_sw_debouncer with DEBOUNCE_CYC=4, NUM_SW=2.
module tb_push_sw_debouncer;

    logic       clk;
    logic       rstb;
    logic [1:0] sw_raw;
    logic [1:0] sw_level;
    logic [1:0] sw_rise;
`ifdef SW_FALL_PULSE_EN
    logic [1:0] sw_fall;
`endif

    int n_tests;
    int n_fail;

    typedef struct {
        logic [1:0] raw;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        string      name;
    } vec_t;

    vec_t vecs[$];

    push_sw_debouncer #(
        .NUM_SW      (2),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk     (clk),
        .rstb    (rstb),
        .sw_raw  (sw_raw),
        .sw_level(sw_level),
        .sw_rise (sw_rise)
`ifdef SW_FALL_PULSE_EN
        ,
        .sw_fall (sw_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic [1:0] raw, input logic [1:0] lvl,
                       input logic [1:0] rise, input logic [1:0] fall, input string name);
        vec_t v;
        v.raw  = raw;
        v.lvl  = lvl;
        v.rise = rise;
        v.fall = fall;
        v.name = name;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk_out(input string name, input logic [1:0] lvl, input logic [1:0] rise,
                           input logic [1:0] fall);
        chk({name, ".level"}, sw_level, lvl);
        chk({name, ".rise"}, sw_rise, rise);
`ifdef SW_FALL_PULSE_EN
        chk({name, ".fall"}, sw_fall, fall);
`else
        if (fall === 2'bxx) n_tests += 0;
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Power-on release with both switches held: rise on both, 6th edge after release
        add(5, 2'b11, 2'b00, 2'b00, 2'b00, "t1_wait");
        add(1, 2'b11, 2'b11, 2'b11, 2'b00, "t1_rise");
        add(1, 2'b11, 2'b11, 2'b00, 2'b00, "t1_after");
        // Both released: level drops (and fall pulses) 6 edges later
        add(5, 2'b00, 2'b11, 2'b00, 2'b00, "t6_wait");
        add(1, 2'b00, 2'b00, 2'b00, 2'b11, "t6_fall");
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, "t6_after");
        // Channel 0 press held 10 cycles
        add(5, 2'b01, 2'b00, 2'b00, 2'b00, "t2_wait");
        add(1, 2'b01, 2'b01, 2'b01, 2'b00, "t2_rise");
        add(4, 2'b01, 2'b01, 2'b00, 2'b00, "t2_hold");
        // Channel 1 glitch 3 cycles wide: rejected
        add(3, 2'b11, 2'b01, 2'b00, 2'b00, "t3_glitch");
        add(6, 2'b01, 2'b01, 2'b00, 2'b00, "t3_after");
        // Channel 0 released
        add(5, 2'b00, 2'b01, 2'b00, 2'b00, "t4_rel_wait");
        add(1, 2'b00, 2'b00, 2'b00, 2'b01, "t4_rel_fall");
        add(2, 2'b00, 2'b00, 2'b00, 2'b00, "t4_idle");
        // Channel 0 bounces 1,0,1,0 then settles at 1
        add(1, 2'b01, 2'b00, 2'b00, 2'b00, "t4_b1");
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, "t4_b0");
        add(1, 2'b01, 2'b00, 2'b00, 2'b00, "t4_b1");
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, "t4_b0");
        add(5, 2'b01, 2'b00, 2'b00, 2'b00, "t4_wait");
        add(1, 2'b01, 2'b01, 2'b01, 2'b00, "t4_rise");
        add(2, 2'b01, 2'b01, 2'b00, 2'b00, "t4_after");

        rstb   = 1'b0;
        sw_raw = 2'b11;
        #6;
        chk_out("t1_in_reset_a", 2'b00, 2'b00, 2'b00);
        #10;
        chk_out("t1_in_reset_b", 2'b00, 2'b00, 2'b00);
        #4;
        rstb = 1'b1;

        foreach (vecs[i]) begin
            sw_raw = vecs[i].raw;
            tick();
            chk_out(vecs[i].name, vecs[i].lvl, vecs[i].rise, vecs[i].fall);
        end

        // Release channel 0, then reset before the fall is accepted
        sw_raw = 2'b00;
        tick();
        chk("t5_pre_a.level", sw_level, 2'b01);
        tick();
        chk("t5_pre_b.level", sw_level, 2'b01);
        #2 rstb = 1'b0;
        #1;
        chk_out("t5_async_reset", 2'b00, 2'b00, 2'b00);
        #3 rstb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out("t5_after_release", 2'b00, 2'b00, 2'b00);
        end

        // Reset mid-count on channel 1: count abandoned, re-debounced afterwards
        sw_raw = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("t7_precount", 2'b00, 2'b00, 2'b00);
        end
        #2 rstb = 1'b0;
        #1;
        chk_out("t7_in_reset", 2'b00, 2'b00, 2'b00);
        #3 rstb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("t7_wait", 2'b00, 2'b00, 2'b00);
        end
        tick();
        chk_out("t7_rise", 2'b10, 2'b10, 2'b00);
        tick();
        chk_out("t7_after", 2'b10, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
